// File: rtl/fmap_pingpong_buf.sv
// Double-buffered feature-map store: the producer fills one bank while the consumer
// drains the other, with banks swapping under a commit/release handshake.
module fmap_pingpong_buf #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   output logic              wr_ready,
   output logic              wr_bank,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_avail,
   output logic              rd_bank,
   output logic [ADDR_W:0]   rd_len,
   input  logic              rd_release,
   output logic [1:0]        occupancy,
   output logic              err_ovf,
   output logic              err_udf
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   logic [1:0]        full;
   logic              wr_sel;
   logic              rd_sel;
   logic [CNT_W-1:0]  wr_cnt;
   logic [CNT_W-1:0]  len [2];

   logic [DATA_W-1:0] mem0 [DEPTH];
   logic [DATA_W-1:0] mem1 [DEPTH];

   logic              wr_acc_c;
   logic              commit_c;
   logic              rd_acc_c;
   logic              rel_c;
   logic [CNT_W-1:0]  cnt_inc_c;
   logic [1:0]        full_nxt_c;

   assign wr_ready  = ~full[wr_sel];
   assign rd_avail  = full[rd_sel];
   assign wr_bank   = wr_sel;
   assign rd_bank   = rd_sel;
   assign occupancy = {1'b0, full[0]} + {1'b0, full[1]};
   assign rd_len    = len[rd_sel];

   // Handshake decode; commit and release always target different banks.
   always_comb begin
      wr_acc_c   = wr_en & wr_ready;
      commit_c   = wr_acc_c & wr_last;
      rd_acc_c   = rd_en & rd_avail;
      rel_c      = rd_release & rd_avail;
      cnt_inc_c  = (wr_cnt == CNT_MAX) ? wr_cnt : wr_cnt + CNT_W'(1);
      full_nxt_c = full;
      if (commit_c) full_nxt_c[wr_sel] = 1'b1;
      if (rel_c)    full_nxt_c[rd_sel] = 1'b0;
   end

   // Bank ownership, write counter and committed lengths.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full   <= '0;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         wr_cnt <= '0;
         len[0] <= '0;
         len[1] <= '0;
      end else begin
         full <= full_nxt_c;
         if (commit_c) begin
            len[wr_sel] <= cnt_inc_c;
            wr_cnt      <= '0;
            wr_sel      <= ~wr_sel;
         end else if (wr_acc_c) begin
            wr_cnt <= cnt_inc_c;
         end
         if (rel_c) rd_sel <= ~rd_sel;
      end
   end

   // Sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else begin
         if (wr_en & ~wr_ready) err_ovf <= 1'b1;
         if (rd_en & ~rd_avail) err_udf <= 1'b1;
      end
   end

   // Write ports of the two banks; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_acc_c && !wr_sel) mem0[wr_addr] <= wr_data;
      if (wr_acc_c &&  wr_sel) mem1[wr_addr] <= wr_data;
   end

   // Registered read from the current read bank; data holds on refused reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_acc_c;
         if (rd_acc_c) rd_data <= rd_sel ? mem1[rd_addr] : mem0[rd_addr];
      end
   end

endmodule

// File: tb/tb_fmap_pingpong_buf.sv
// Self-checking bench for fmap_pingpong_buf: directed scenarios plus random traffic
// checked against a commit/release counting model of the two banks.
module tb_fmap_pingpong_buf;

   localparam int unsigned DW    = 64;
   localparam int unsigned AW    = 9;
   localparam int unsigned DEPTH = 512;

   logic          clk;
   logic          rst_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_last;
   logic          wr_ready;
   logic          wr_bank;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_avail;
   logic          rd_bank;
   logic [AW:0]   rd_len;
   logic          rd_release;
   logic [1:0]    occupancy;
   logic          err_ovf;
   logic          err_udf;

   fmap_pingpong_buf #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
      .wr_ready(wr_ready), .wr_bank(wr_bank),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_avail(rd_avail), .rd_bank(rd_bank), .rd_len(rd_len), .rd_release(rd_release),
      .occupancy(occupancy), .err_ovf(err_ovf), .err_udf(err_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: banks are used strictly in turn, so the write bank is commits mod 2,
   // the read bank is releases mod 2 and occupancy is commits minus releases.
   int          commits;
   int          releases;
   int          wcnt;
   int          mlen [2];
   logic [63:0] mmem [2][DEPTH];
   bit          mwr  [2][DEPTH];
   bit          movf;
   bit          mudf;
   bit          mvalid;
   bit          mknown;
   logic [63:0] mdata;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      commits  = 0;
      releases = 0;
      wcnt     = 0;
      mlen[0]  = 0;
      mlen[1]  = 0;
      movf     = 1'b0;
      mudf     = 1'b0;
      mvalid   = 1'b0;
      mknown   = 1'b1;
      mdata    = '0;
   endtask

   task automatic model_update();
      int occ;
      int wb;
      int rb;
      int ra;
      int wa;
      occ = commits - releases;
      wb  = commits % 2;
      rb  = releases % 2;
      ra  = int'(rd_addr);
      wa  = int'(wr_addr);
      mvalid = rd_en && occ > 0;
      if (rd_en && occ == 0) mudf = 1'b1;
      if (wr_en && occ == 2) movf = 1'b1;
      if (mvalid) begin
         mknown = mwr[rb][ra];
         mdata  = mmem[rb][ra];
      end
      if (wr_en && occ < 2) begin
         mmem[wb][wa] = wr_data;
         mwr[wb][wa]  = 1'b1;
         if (wr_last) begin
            mlen[wb] = (wcnt + 1 > int'(DEPTH)) ? int'(DEPTH) : wcnt + 1;
            wcnt     = 0;
            commits++;
         end else begin
            wcnt = (wcnt + 1 > int'(DEPTH)) ? int'(DEPTH) : wcnt + 1;
         end
      end
      if (rd_release && occ > 0) releases++;
   endtask

   task automatic check_outputs();
      int occ;
      occ = commits - releases;
      check("wr_ready",  64'(wr_ready),  64'(occ < 2));
      check("rd_avail",  64'(rd_avail),  64'(occ > 0));
      check("wr_bank",   64'(wr_bank),   64'(commits % 2));
      check("rd_bank",   64'(rd_bank),   64'(releases % 2));
      check("occupancy", 64'(occupancy), 64'(occ));
      check("rd_len",    64'(rd_len),    64'(mlen[releases % 2]));
      check("err_ovf",   64'(err_ovf),   64'(movf));
      check("err_udf",   64'(err_udf),   64'(mudf));
      check("rd_valid",  64'(rd_valid),  64'(mvalid));
      if (mknown) check("rd_data", rd_data, mdata);
   endtask

   // One clock with the given inputs held across the edge; checks #1 after the edge.
   task automatic drive(input bit we, input int wa, input logic [63:0] wd, input bit wl,
                        input bit re, input int ra, input bit rel);
      wr_en      = we;
      wr_addr    = AW'(wa);
      wr_data    = wd;
      wr_last    = wl;
      rd_en      = re;
      rd_addr    = AW'(ra);
      rd_release = rel;
      @(posedge clk);
      model_update();
      #1;
      check_outputs();
      wr_en      = 1'b0;
      wr_last    = 1'b0;
      rd_en      = 1'b0;
      rd_release = 1'b0;
   endtask

   // Asserts reset away from a clock edge and checks the outputs before any edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      wr_last    = 1'b0;
      rd_en      = 1'b0;
      rd_addr    = '0;
      rd_release = 1'b0;
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < int'(DEPTH); a++) mwr[b][a] = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // Fill bank 0 with addr*3 and commit on address 15.
      for (int i = 0; i < 16; i++) drive(1'b1, i, 64'(i * 3), i == 15, 1'b0, 0, 1'b0);
      check("t1_wr_bank", 64'(wr_bank),   64'd1);
      check("t1_avail",   64'(rd_avail),  64'd1);
      check("t1_len",     64'(rd_len),    64'd16);
      check("t1_occ",     64'(occupancy), 64'd1);

      // Back-to-back reads: one word per cycle, one cycle latency.
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 0, '0, 1'b0, 1'b1, i, 1'b0);
         check("t2_valid", 64'(rd_valid), 64'd1);
         check("t2_data",  rd_data,       64'(i * 3));
      end
      drive(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b0);
      check("t2_valid_end", 64'(rd_valid), 64'd0);

      // Commit bank 1 too, then a refused write must not touch memory.
      for (int i = 0; i < 4; i++) drive(1'b1, i, 64'(100 + i), i == 3, 1'b0, 0, 1'b0);
      check("t3_occ2",  64'(occupancy), 64'd2);
      check("t3_ready", 64'(wr_ready),  64'd0);
      drive(1'b1, 0, 64'hdead, 1'b0, 1'b0, 0, 1'b0);
      check("t3_ovf",   64'(err_ovf),   64'd1);
      drive(1'b0, 0, '0, 1'b0, 1'b1, 0, 1'b0);
      check("t3_mem_kept", rd_data, 64'd0);
      drive(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b1);
      check("t3_rel_ready", 64'(wr_ready),  64'd1);
      check("t3_rel_wbank", 64'(wr_bank),   64'd0);
      check("t3_rel_occ",   64'(occupancy), 64'd1);

      // Underflow read and ignored release with nothing committed.
      do_reset();
      drive(1'b0, 0, '0, 1'b0, 1'b1, 3, 1'b0);
      check("t4_valid", 64'(rd_valid), 64'd0);
      check("t4_udf",   64'(err_udf),  64'd1);
      drive(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b1);
      check("t4_rbank", 64'(rd_bank),   64'd0);
      check("t4_occ",   64'(occupancy), 64'd0);

      // Commit of bank 1 in the same cycle as release of bank 0.
      do_reset();
      for (int i = 0; i < 4; i++) drive(1'b1, i, 64'(i + 7), i == 3, 1'b0, 0, 1'b0);
      for (int i = 0; i < 7; i++) drive(1'b1, i, 64'(i + 50), 1'b0, 1'b0, 0, 1'b0);
      drive(1'b1, 7, 64'd57, 1'b1, 1'b0, 0, 1'b1);
      check("t5_occ",    64'(occupancy), 64'd1);
      check("t5_rbank",  64'(rd_bank),   64'd1);
      check("t5_len",    64'(rd_len),    64'd8);
      check("t5_wbank",  64'(wr_bank),   64'd0);
      check("t5_ready",  64'(wr_ready),  64'd1);
      drive(1'b0, 0, '0, 1'b0, 1'b1, 7, 1'b0);
      check("t5_data",   rd_data,        64'd57);

      // Asynchronous reset in the middle of filling bank 1.
      do_reset();
      for (int i = 0; i < 4; i++) drive(1'b1, i, 64'(i + 200), i == 3, 1'b0, 0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, i, 64'(i + 300), 1'b0, 1'b0, 0, 1'b0);
      do_reset();
      check("t6_ready", 64'(wr_ready),  64'd1);
      check("t6_occ",   64'(occupancy), 64'd0);
      check("t6_wbank", 64'(wr_bank),   64'd0);
      for (int i = 0; i < 4; i++) drive(1'b1, i, 64'(i + 400), i == 3, 1'b0, 0, 1'b0);
      check("t6_rbank", 64'(rd_bank), 64'd0);
      check("t6_len",   64'(rd_len),  64'd4);
      check("t6_wbank2", 64'(wr_bank), 64'd1);
      drive(1'b0, 0, '0, 1'b0, 1'b1, 2, 1'b0);
      check("t6_data",  rd_data, 64'd402);

      // Length saturates at DEPTH when more writes than words arrive.
      do_reset();
      for (int i = 0; i < 520; i++)
         drive(1'b1, i % int'(DEPTH), 64'(i), i == 519, 1'b0, 0, 1'b0);
      check("t7_len_sat", 64'(rd_len), 64'(DEPTH));

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         drive(($urandom % 3) != 0, int'($urandom % 32), {$urandom, $urandom},
               ($urandom % 12) == 0, ($urandom % 2) == 0, int'($urandom % 32),
               ($urandom % 10) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
